// File: rtl/tsp16_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tsp16_mem_pkg
//  Description : Shared types and default widths for the TSP16 unified
//                memory path (read-owner encoding, address/data widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package tsp16_mem_pkg;

   // Default widths of the unified TSP16 memory
   localparam int C_ADDR_W = 16;
   localparam int C_DATA_W = 16;

   // Owner of the read currently in flight to the memory
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_EXEC  = 2'd2
   } owner_t;

endpackage : tsp16_mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates the single-ported TSP16 memory between the fetch
//                stage and the execute stage. Execute has priority; a
//                starvation counter forces a fetch grant after MAX_EXEC_RUN
//                consecutive execute wins. Read data returns one cycle after
//                grant to the owner recorded in r_owner_q.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import tsp16_mem_pkg::*;
#(
   parameter int ADDR_W       = C_ADDR_W,
   parameter int DATA_W       = C_DATA_W,
   parameter int MAX_EXEC_RUN = 4
) (
   input  logic              clk,
   input  logic              reset,
   // fetch port
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_flush,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   // execute port
   input  logic              exec_req,
   input  logic              exec_we,
   input  logic [ADDR_W-1:0] exec_addr,
   input  logic [DATA_W-1:0] exec_wdata,
   output logic              exec_ready,
   output logic              exec_valid,
   output logic [DATA_W-1:0] exec_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] C_MAX_RUN = 4'(MAX_EXEC_RUN);

   logic       w_run;
   logic       w_starved;
   logic       w_exec_gnt;
   logic       w_fetch_gnt;
   logic [3:0] r_starve_cnt;
   logic [3:0] w_starve_nxt;
   owner_t     r_owner_q;
   owner_t     w_owner_nxt;

   // Reset is active-low; while it is held every grant is suppressed so the
   // combinational outputs read zero immediately, not just after a clock.
   assign w_run       = reset;
   assign w_starved   = (r_starve_cnt == C_MAX_RUN);
   assign w_exec_gnt  = w_run & exec_req & ~(fetch_req & w_starved);
   assign w_fetch_gnt = w_run & fetch_req & ~w_exec_gnt;

   // Grant outputs and memory command mux; idle cycles drive zeros
   always_comb begin
      fetch_ready = w_fetch_gnt;
      exec_ready  = w_exec_gnt;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (w_exec_gnt) begin
         mem_en    = 1'b1;
         mem_we    = exec_we;
         mem_addr  = exec_addr;
         mem_wdata = exec_wdata;
      end else if (w_fetch_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = fetch_addr;
      end
   end

   // Next value of the starvation counter: counts execute wins that made a
   // waiting fetch lose, saturating at the limit that flips priority.
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!fetch_req || w_fetch_gnt) begin
         w_starve_nxt = 4'd0;
      end else if (w_exec_gnt && (r_starve_cnt < C_MAX_RUN)) begin
         w_starve_nxt = r_starve_cnt + 4'd1;
      end
   end

   // Next owner of the read in flight; stores and idle cycles leave no owner
   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_fetch_gnt) begin
         w_owner_nxt = OWN_FETCH;
      end else if (w_exec_gnt && !exec_we) begin
         w_owner_nxt = OWN_EXEC;
      end
   end

   // State registers; reset drops any read in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= 4'd0;
         r_owner_q    <= OWN_NONE;
      end else begin
         r_starve_cnt <= w_starve_nxt;
         r_owner_q    <= w_owner_nxt;
      end
   end

   // Read return routing; a flush kills a fetch return in the same cycle
   always_comb begin
      fetch_valid = (r_owner_q == OWN_FETCH) && !fetch_flush;
      exec_valid  = (r_owner_q == OWN_EXEC);
      fetch_data  = fetch_valid ? mem_rdata : '0;
      exec_rdata  = exec_valid  ? mem_rdata : '0;
      busy        = (r_owner_q != OWN_NONE);
   end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A vector table drives
//                requests cycle by cycle with the expected grants; expected
//                read returns are queued at grant and popped one cycle later.
//                Hand-written sequences cover reset during a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int MAXR = 4;
   localparam int NV   = 22;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req, fetch_flush, fetch_ready, fetch_valid;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;
   logic          exec_req, exec_we, exec_ready, exec_valid;
   logic [AW-1:0] exec_addr;
   logic [DW-1:0] exec_wdata, exec_rdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_EXEC_RUN(MAXR)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
      .exec_wdata(exec_wdata), .exec_ready(exec_ready), .exec_valid(exec_valid),
      .exec_rdata(exec_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Synchronous memory model: read word is 0xA000 + address
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= 16'hA000 + mem_addr;
   end

   typedef struct {
      logic          fr;  logic [15:0] fa; logic fl;
      logic          er;  logic        we; logic [15:0] ea; logic [15:0] ed;
      logic          xf;  logic        xe;
   } vec_t;

   typedef struct {
      logic [1:0]  kind;   // 0 none, 1 fetch, 2 exec
      logic [15:0] data;
   } ret_t;

   vec_t vt [NV];
   ret_t sb [$];

   function automatic vec_t mk(input logic fr, input logic [15:0] fa, input logic fl,
                               input logic er, input logic we, input logic [15:0] ea,
                               input logic [15:0] ed, input logic xf, input logic xe);
      vec_t v;
      v.fr = fr; v.fa = fa; v.fl = fl; v.er = er; v.we = we;
      v.ea = ea; v.ed = ed; v.xf = xf; v.xe = xe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic drive(input vec_t v);
      fetch_req = v.fr; fetch_addr = v.fa; fetch_flush = v.fl;
      exec_req = v.er; exec_we = v.we; exec_addr = v.ea; exec_wdata = v.ed;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " fetch_ready"}, {31'd0, fetch_ready}, 0);
      chk({tag, " exec_ready"},  {31'd0, exec_ready},  0);
      chk({tag, " mem_en"},      {31'd0, mem_en},      0);
      chk({tag, " mem_we"},      {31'd0, mem_we},      0);
      chk({tag, " mem_addr"},    {16'd0, mem_addr},    0);
      chk({tag, " mem_wdata"},   {16'd0, mem_wdata},   0);
      chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, 0);
      chk({tag, " exec_valid"},  {31'd0, exec_valid},  0);
      chk({tag, " fetch_data"},  {16'd0, fetch_data},  0);
      chk({tag, " exec_rdata"},  {16'd0, exec_rdata},  0);
      chk({tag, " busy"},        {31'd0, busy},        0);
   endtask

   initial begin
      ret_t  r;
      ret_t  nr;
      logic  xfv, xev;
      logic [15:0] xaddr;

      //            fr  fa       fl  er  we  ea       ed        xf  xe
      vt[0]  = mk(1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0); // fetch only
      vt[1]  = mk(1, 16'h0011, 0, 0, 0, 16'h0000, 16'h0000, 1, 0);
      vt[2]  = mk(1, 16'h0012, 0, 0, 0, 16'h0000, 16'h0000, 1, 0);
      vt[3]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[4]  = mk(1, 16'h0030, 0, 1, 0, 16'h0100, 16'h0000, 0, 1); // collision
      vt[5]  = mk(1, 16'h0030, 0, 0, 0, 16'h0000, 16'h0000, 1, 0);
      vt[6]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[7]  = mk(1, 16'h0050, 0, 1, 0, 16'h0101, 16'h0000, 0, 1); // starvation
      vt[8]  = mk(1, 16'h0050, 0, 1, 0, 16'h0102, 16'h0000, 0, 1);
      vt[9]  = mk(1, 16'h0050, 0, 1, 0, 16'h0103, 16'h0000, 0, 1);
      vt[10] = mk(1, 16'h0050, 0, 1, 0, 16'h0104, 16'h0000, 0, 1);
      vt[11] = mk(1, 16'h0050, 0, 1, 0, 16'h0105, 16'h0000, 1, 0);
      vt[12] = mk(1, 16'h0051, 0, 1, 0, 16'h0105, 16'h0000, 0, 1);
      vt[13] = mk(1, 16'h0051, 0, 0, 0, 16'h0000, 16'h0000, 1, 0);
      vt[14] = mk(1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 1, 0); // flush
      vt[15] = mk(1, 16'h0040, 1, 0, 0, 16'h0000, 16'h0000, 1, 0);
      vt[16] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[17] = mk(0, 16'h0000, 0, 1, 1, 16'h0200, 16'hBEEF, 0, 1); // store
      vt[18] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[19] = mk(1, 16'h0060, 0, 0, 0, 16'h0000, 16'h0000, 1, 0); // F then E
      vt[20] = mk(0, 16'h0000, 0, 1, 0, 16'h0110, 16'h0000, 0, 1);
      vt[21] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);

      // Reset held with both requesters asking: everything must stay zero
      reset = 1'b0;
      drive(mk(1, 16'h0033, 0, 1, 0, 16'h0133, 16'h1234, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("in_reset");

      // Release reset and apply the first vector in the same cycle
      reset = 1'b1;
      nr.kind = 2'd0; nr.data = 16'h0;
      sb.push_back(nr);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         @(negedge clk);
         chk($sformatf("v%0d fetch_ready", i), {31'd0, fetch_ready}, {31'd0, vt[i].xf});
         chk($sformatf("v%0d exec_ready", i),  {31'd0, exec_ready},  {31'd0, vt[i].xe});
         chk($sformatf("v%0d mem_en", i), {31'd0, mem_en}, {31'd0, vt[i].xf | vt[i].xe});
         chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vt[i].xe & vt[i].we});
         xaddr = vt[i].xf ? vt[i].fa : (vt[i].xe ? vt[i].ea : 16'h0);
         chk($sformatf("v%0d mem_addr", i), {16'd0, mem_addr}, {16'd0, xaddr});
         if (!vt[i].xf)
            chk($sformatf("v%0d mem_wdata", i), {16'd0, mem_wdata},
                {16'd0, (vt[i].xe ? vt[i].ed : 16'h0)});
         if (i == 12)
            chk("starve_cnt after fetch grant", {28'd0, dut.r_starve_cnt}, 32'd0);

         if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", i), 32'd1, 32'd0);
            r.kind = 2'd0; r.data = 16'h0;
         end else begin
            r = sb.pop_front();
         end
         xfv = (r.kind == 2'd1) && !vt[i].fl;
         xev = (r.kind == 2'd2);
         chk($sformatf("v%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, xfv});
         chk($sformatf("v%0d fetch_data", i),  {16'd0, fetch_data},  {16'd0, (xfv ? r.data : 16'h0)});
         chk($sformatf("v%0d exec_valid", i),  {31'd0, exec_valid},  {31'd0, xev});
         chk($sformatf("v%0d exec_rdata", i),  {16'd0, exec_rdata},  {16'd0, (xev ? r.data : 16'h0)});
         chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, (r.kind != 2'd0)});

         if (vt[i].xf)                     begin nr.kind = 2'd1; nr.data = 16'hA000 + vt[i].fa; end
         else if (vt[i].xe && !vt[i].we)   begin nr.kind = 2'd2; nr.data = 16'hA000 + vt[i].ea; end
         else                              begin nr.kind = 2'd0; nr.data = 16'h0; end
         sb.push_back(nr);
         @(posedge clk);
         #1;
      end
      sb.delete();

      // Reset arriving while an execute load is in flight
      drive(mk(0, 16'h0000, 0, 1, 0, 16'h0120, 16'h0000, 0, 0));
      @(negedge clk);
      chk("rst_mid exec_ready", {31'd0, exec_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      exec_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst exec_valid", {31'd0, exec_valid}, 32'd0);
      chk("post_rst busy",       {31'd0, busy},       32'd0);
      @(posedge clk);
      #1;
      chk("post_rst exec_valid 2", {31'd0, exec_valid}, 32'd0);

      // A fresh grant after reset returns normally
      fetch_req = 1'b1; fetch_addr = 16'h0070;
      @(negedge clk);
      chk("post_rst fetch_ready", {31'd0, fetch_ready}, 32'd1);
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      @(negedge clk);
      chk("post_rst fetch_valid", {31'd0, fetch_valid}, 32'd1);
      chk("post_rst fetch_data",  {16'd0, fetch_data},  32'h0000A070);
      chk("post_rst exec_valid 3", {31'd0, exec_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-ported unified TSP16 memory between two requesters:
  - the fetch stage (instruction reads);
  - the execute stage (load/store).
- Grants at most one access per cycle, issues it to the memory and routes the read data back to its owner one cycle later.
- Execute has priority, because it stalls the whole pipeline. A starvation counter guarantees fetch forward progress.
- A fetch flush input discards an in-flight instruction read after a taken branch.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory data width
- `MAX_EXEC_RUN`, 4, max consecutive execute grants while fetch waits (range 1–15)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `fetch_req`  in  1  fetch wants an instruction read
- `fetch_addr`  in  ADDR_W  instruction address
- `fetch_flush`  in  1  discard any in-flight fetch read
- `fetch_ready`  out  1  fetch request granted this cycle
- `fetch_valid`  out  1  instruction data valid this cycle
- `fetch_data`  out  DATA_W  instruction word
- `exec_req`  in  1  execute wants a memory access
- `exec_we`  in  1  1 = store, 0 = load
- `exec_addr`  in  ADDR_W  data address
- `exec_wdata`  in  DATA_W  store data
- `exec_ready`  out  1  execute request granted this cycle
- `exec_valid`  out  1  load data valid this cycle
- `exec_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  synchronous read data, valid the cycle after a read
- `busy`  out  1  a read is in flight

## Operation
**Requests and grants**
- Requests are level-sensitive. The requester holds req, addr, we and wdata stable until it sees its ready high.
- Ready is combinational from the current-cycle requests and state. Exactly one of `fetch_ready`/`exec_ready` can be high per cycle.

**Grant rule**
- Only one requester: that requester wins.
- Both requesting and `starve_cnt < MAX_EXEC_RUN`: execute wins.
- Both requesting and `starve_cnt == MAX_EXEC_RUN`: fetch wins.

**Starvation counter (`starve_cnt`)**
- Width 4 bits, saturating at `MAX_EXEC_RUN`.
- Increments on an execute grant while `fetch_req` is high.
- Clears on a fetch grant, or in any cycle where `fetch_req` is low.

**Memory side**
- On a grant: `mem_en=1`; `mem_addr`, `mem_we` and `mem_wdata` come from the winner.
- Fetch grants always have `mem_we=0`.
- With no grant: `mem_en=0`, `mem_we=0`. `mem_addr` and `mem_wdata` are don't-care, but the implementation drives 0.

**Read return (`owner_q`)**
- A registered `owner_q` records who owns the read in flight: NONE, FETCH or EXEC.
  - Set to FETCH on a fetch grant.
  - Set to EXEC on an execute load grant.
  - Set to NONE otherwise, including on stores.
- `fetch_valid = (owner_q==FETCH) && !fetch_flush`.
- `exec_valid = (owner_q==EXEC)`.
- Data outputs pass `mem_rdata` through when their valid is high, and are 0 otherwise.
- `busy = (owner_q != NONE)`.

**Flush**
- `fetch_flush` kills a fetch read granted in the previous cycle.
- It does not block a fetch grant in the flush cycle; that new read returns normally.

**Stores**
- A store completes at grant. No valid pulse is produced.

## Timing
- Grant-to-data latency is 1 cycle. Throughput is 1 access per cycle, back-to-back, with no bubbles between grants.
- Reset asserted: all outputs 0, `owner_q=NONE`, `starve_cnt=0`, and requests are ignored.
- Reset mid-read: the read is dropped and no valid pulse follows reset release.
- First grant is possible in the first cycle after reset deasserts.
- Flush and a fetch return in the same cycle: the return is suppressed. An execute return is unaffected.
- A fetch grant in cycle N, followed by an execute grant in cycle N+1, returns `fetch_valid` in N+1 and `exec_valid` in N+2.

## Structure
- Shared package `tsp16_mem_pkg` holds:
  - `owner_t` enum {OWN_NONE, OWN_FETCH, OWN_EXEC};
  - `ADDR_W`/`DATA_W` defaults.
- Single module, no sub-modules. The starvation counter and owner register are inline, at roughly 150 lines total.

## Test plan
- **Fetch only:** `fetch_req` high with addr 0x0010, 0x0011, 0x0012 over 3 cycles, memory returning 0xA000+addr.
  - Expect `fetch_ready` every cycle.
  - Expect `fetch_valid` in cycles 2–4 carrying 0xA010, 0xA011, 0xA012.
- **Collision:** `fetch_req` and `exec_req` both high for one cycle (load 0x0100).
  - Expect `exec_ready=1`, `fetch_ready=0`.
  - Next cycle: `exec_valid` with `mem_rdata`; fetch is then granted.
- **Starvation:** both requesting continuously, execute loads, `MAX_EXEC_RUN=4`.
  - Expect 4 execute grants, then 1 fetch grant, then execute again.
  - `starve_cnt` resets to 0 after the fetch grant.
- **Flush:** fetch granted at 0x0020 in cycle N, `fetch_flush` high in N+1 while fetch is granted at 0x0040.
  - Expect `fetch_valid=0` in N+1.
  - Expect `fetch_valid=1` with data for 0x0040 in N+2.
- **Store:** `exec_req`, `exec_we=1`, addr 0x0200, wdata 0xBEEF.
  - Expect `mem_en=1`, `mem_we=1`, `mem_addr=0x0200`, `mem_wdata=0xBEEF`.
  - No `exec_valid` in the next cycle.
- **Reset mid-read:** load granted, then `reset` driven low in the next cycle before the clock edge.
  - Expect all outputs 0 immediately.
  - After release, no `exec_valid` until a new grant.
